irq_pending_ctrl: RTL and testbench
===================================

Name: irq_pending_ctrl

Overview:
- Upstream feeder for the team's 16-input priority_encoder.
- Captures rising edges on 16 interrupt request lines into sticky pending bits, applies a mask, and drives the masked pending vector into the encoder.
- Registers the encoder's returned code, then presents it to the CPU side with a valid/ack handshake.
- On ack, clears the serviced pending bit.

Parameters:
- N, 16, number of request lines; must equal the priority_encoder input width.
- CODE_W, 4, code width; must satisfy 2**CODE_W >= N.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- irq_in  in  N  raw request lines, already synchronous to clk.
- mask_wr  in  1  load mask_data into mask register this cycle.
- mask_data  in  N  1 = line enabled.
- pend_vec  out  N  pending & mask; connects to the priority_encoder input.
- enc_code  in  CODE_W  code returned by the priority_encoder for pend_vec.
- irq_valid  out  1  irq_code is valid; held until ack.
- irq_code  out  CODE_W  index of the line being serviced.
- irq_ack  in  1  CPU has taken irq_code.

Behaviour:
- Reset values: pending=0, irq_q=0, mask=0 (all disabled), pend_vec=0, irq_valid=0, irq_code=0, state=IDLE.
- Edge detect: irq_q<=irq_in every cycle. At edge E, if irq_in[i]=1 and irq_q[i]=0, then pending[i]<=1.
- pend_vec = pending & mask. It is a combinational function of registers only, so there is no input-to-output combinational path.
- mask_wr: mask<=mask_data at the edge.
- FSM states: IDLE, WAIT_ACK, GAP.
  - IDLE: if pend_vec != 0, then irq_code<=enc_code, irq_valid<=1, go to WAIT_ACK. Otherwise stay in IDLE.
  - WAIT_ACK: irq_code and irq_valid are held stable regardless of irq_in, mask or enc_code changes. When irq_ack=1: pending[irq_code]<=0, irq_valid<=0, go to GAP.
  - GAP: one cycle; irq_valid stays 0. Go to IDLE unconditionally. This guarantees at least one low cycle between grants and lets pend_vec settle.
- Latency: rising edge of irq_in sampled at E0 → pending set at E0 → irq_valid high after E1, i.e. 2 edges after irq_in goes high. Back-to-back grants are separated by 2 low cycles (ack edge, GAP).
- Simultaneous set and clear on the same bit at the ack edge: set wins; the bit stays pending and is re-granted later.
- Mask cleared for a pending bit: the bit stays pending but is invisible in pend_vec. It reappears when the mask is re-enabled; no edge is lost.
- Mask change while in WAIT_ACK: does not affect the held irq_code; ack still clears that bit.
- irq_ack while not in WAIT_ACK: ignored.
- An edge on an already-pending bit is coalesced, with no extra grant.
- enc_code is trusted only when pend_vec != 0. Out-of-range codes (>= N) clear nothing.
- rst asserted mid-handshake: everything returns to reset values at that edge. Edges occurring during reset are lost, because irq_q tracks irq_in.

Optional Feature:
- Macro IRQ_OVERFLOW_CNT_EN.
- When defined:
  - Adds output overflow_cnt [7:0].
  - overflow_cnt increments once per edge at which one or more rising edges hit already-pending bits (including the set-wins case).
  - Saturates at 255; reset to 0.
  - Adds input overflow_clr, which zeroes the count synchronously. If overflow_clr and an increment occur on the same edge, the clear wins.
- When undefined: no port, no logic; behaviour otherwise identical.

Decomposition:
- Package irq_pkg holds: N, CODE_W defaults; state enum {IDLE, WAIT_ACK, GAP}; overflow counter width (8).
- One natural sub-module: irq_edge_detect.
  - Owns the N-bit irq_q register.
  - Outputs rise[N-1:0] = irq_in & ~irq_q.
  - Uses the same clk/rst.

Test Plan:
- Bench drives enc_code from a model of priority_encoder (index of highest set bit of pend_vec).
- Reset: assert rst 2 cycles with irq_in=16'hFFFF → all outputs 0; after release with irq_in held high, no pending bits (no edge).
- Single edge: mask=16'hFFFF, irq_in 0→16'h0010 → irq_valid=1 and irq_code=4 two edges later; held until irq_ack; pend_vec=0 after ack edge; irq_valid low for ack cycle plus GAP.
- Multiple pending: edges on bits 1 and 3 in the same cycle (16'h000A) → grant code 3, ack, GAP, then grant code 1, ack, pend_vec=0.
- Masking: mask=16'hFF7F, edge on bit 7 → no irq_valid, pend_vec=0; write mask=16'hFFFF → code 7 granted.
- Set-wins: re-pulse irq_in[9] 0→1 timed so its rising edge coincides with the ack edge for code 9 → bit 9 re-granted after GAP. With IRQ_OVERFLOW_CNT_EN, overflow_cnt=1.
- Reset mid-handshake: rst while irq_valid=1 with code 2 → next cycle irq_valid=0, pend_vec=0, state IDLE; irq_ack the following cycle ignored.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt pending controller: default widths,
// handshake FSM state encoding and overflow counter width.
// Optional feature macro: IRQ_OVERFLOW_CNT_EN (overflow counter).
package irq_pkg;

   localparam int IRQ_N      = 16;  // request lines, equals priority_encoder width
   localparam int IRQ_CODE_W = 4;   // encoder code width
   localparam int OVF_W      = 8;   // overflow counter width

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_ACK = 2'd1,
      GAP      = 2'd2
   } irq_state_t;

endpackage

// File: rtl/irq_edge_detect.sv
// Rising-edge detector for the raw request lines.
// irq_q follows irq_in on every edge, reset included, so a line that is
// already high when reset releases is not mistaken for a fresh edge.
module irq_edge_detect #(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] irq_in,
   output logic [N-1:0] rise
);

   logic [N-1:0] irq_q_reg;

   // Sample the request lines every cycle; reset does not blank the history
   // so edges that happen during reset are absorbed rather than replayed.
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_q_reg <= irq_in;
      end else begin
         irq_q_reg <= irq_in;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_rise
         assign rise[gi] = irq_in[gi] & ~irq_q_reg[gi];
      end
   endgenerate

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt pending controller: sticky pending bits from rising edges,
// mask register, masked vector to an external priority encoder, and a
// valid/ack handshake towards the CPU with a one-cycle gap between grants.
// Optional feature macro: IRQ_OVERFLOW_CNT_EN adds overflow_cnt/overflow_clr,
// counting edges at which a rising edge lands on an already-pending bit.
module irq_pending_ctrl
   import irq_pkg::*;
#(
   parameter int N      = IRQ_N,
   parameter int CODE_W = IRQ_CODE_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N-1:0]      irq_in,
   input  logic              mask_wr,
   input  logic [N-1:0]      mask_data,
   output logic [N-1:0]      pend_vec,
   input  logic [CODE_W-1:0] enc_code,
   output logic              irq_valid,
   output logic [CODE_W-1:0] irq_code,
   input  logic              irq_ack
`ifdef IRQ_OVERFLOW_CNT_EN
   ,
   output logic [OVF_W-1:0]  overflow_cnt,
   input  logic              overflow_clr
`endif
);

   irq_state_t        state_reg;
   irq_state_t        state_next;
   logic [N-1:0]      pending_reg;
   logic [N-1:0]      pending_next;
   logic [N-1:0]      mask_reg;
   logic [CODE_W-1:0] code_reg;
   logic [N-1:0]      rise;
   logic [N-1:0]      clr_vec;
   logic              load_code;
   logic              clr_en;
   logic              valid_int;

   irq_edge_detect #(.N(N)) u_edge (
      .clk    (clk),
      .rst    (rst),
      .irq_in (irq_in),
      .rise   (rise)
   );

   // Registers only feed pend_vec, so there is no input-to-output path.
   assign pend_vec  = pending_reg & mask_reg;
   assign irq_valid = valid_int;
   assign irq_code  = code_reg;

   // Decode the serviced code into a one-hot clear; codes >= N match nothing.
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_clr
         assign clr_vec[gi] = clr_en && (int'(code_reg) == gi);
      end
   endgenerate

   // Clear first, then OR in new edges so a coinciding edge keeps the bit set.
   always_comb begin
      pending_next = (pending_reg & ~clr_vec) | rise;
   end

   // Pending bits and mask register.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_reg <= '0;
         mask_reg    <= '0;
      end else begin
         pending_reg <= pending_next;
         if (mask_wr) begin
            mask_reg <= mask_data;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:     if (pend_vec != '0) state_next = WAIT_ACK;
         WAIT_ACK: if (irq_ack)        state_next = GAP;
         GAP:                          state_next = IDLE;
         default:                      state_next = IDLE;
      endcase
   end

   // FSM outputs: grant strobe, clear strobe and the valid flag.
   always_comb begin
      load_code = 1'b0;
      clr_en    = 1'b0;
      valid_int = 1'b0;
      case (state_reg)
         IDLE:     load_code = (pend_vec != '0);
         WAIT_ACK: begin
            valid_int = 1'b1;
            clr_en    = irq_ack;
         end
         default: ;
      endcase
   end

   // Capture the encoder result only when granting; held through WAIT_ACK.
   always_ff @(posedge clk) begin
      if (rst) begin
         code_reg <= '0;
      end else if (load_code) begin
         code_reg <= enc_code;
      end
   end

`ifdef IRQ_OVERFLOW_CNT_EN
   logic [OVF_W-1:0] ovf_cnt_reg;
   logic             ovf_hit;

   // Any rising edge on a bit that is pending before this edge is an overflow.
   assign ovf_hit      = |(rise & pending_reg);
   assign overflow_cnt = ovf_cnt_reg;

   // Saturating overflow counter; clear beats increment.
   always_ff @(posedge clk) begin
      if (rst || overflow_clr) begin
         ovf_cnt_reg <= '0;
      end else if (ovf_hit && (ovf_cnt_reg != {OVF_W{1'b1}})) begin
         ovf_cnt_reg <= ovf_cnt_reg + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed self-checking bench for irq_pending_ctrl. enc_code is driven by a
// model of the priority encoder (index of the highest set bit of pend_vec).
// Inputs change and outputs are checked on the falling clock edge.
module tb_irq_pending_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] irq_in;
   logic        mask_wr;
   logic [15:0] mask_data;
   logic [15:0] pend_vec;
   logic [3:0]  enc_code;
   logic        irq_valid;
   logic [3:0]  irq_code;
   logic        irq_ack;
`ifdef IRQ_OVERFLOW_CNT_EN
   logic [7:0]  overflow_cnt;
   logic        overflow_clr;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   irq_pending_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .irq_in       (irq_in),
      .mask_wr      (mask_wr),
      .mask_data    (mask_data),
      .pend_vec     (pend_vec),
      .enc_code     (enc_code),
      .irq_valid    (irq_valid),
      .irq_code     (irq_code),
      .irq_ack      (irq_ack)
`ifdef IRQ_OVERFLOW_CNT_EN
      ,
      .overflow_cnt (overflow_cnt),
      .overflow_clr (overflow_clr)
`endif
   );

   // Priority encoder model: highest set bit wins.
   always_comb begin
      enc_code = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (pend_vec[i]) enc_code = 4'(i);
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   initial begin
      rst = 1'b1; irq_in = 16'hFFFF; mask_wr = 1'b0; mask_data = 16'h0000; irq_ack = 1'b0;
`ifdef IRQ_OVERFLOW_CNT_EN
      overflow_clr = 1'b0;
`endif
      // Reset with all lines high
      tick(); tick();
      check("rst_valid", 16'(irq_valid), 16'd0);
      check("rst_code", 16'(irq_code), 16'd0);
      check("rst_pend", pend_vec, 16'h0000);
      rst = 1'b0; mask_wr = 1'b1; mask_data = 16'hFFFF;
      tick();
      mask_wr = 1'b0;
      tick(); tick();
      check("post_rst_pend", pend_vec, 16'h0000);
      check("post_rst_valid", 16'(irq_valid), 16'd0);

      // Single edge on bit 4
      irq_in = 16'h0000; tick();
      irq_in = 16'h0010; tick();
      check("single_pend_e0", pend_vec, 16'h0010);
      check("single_valid_e0", 16'(irq_valid), 16'd0);
      tick();
      check("single_valid_e1", 16'(irq_valid), 16'd1);
      check("single_code", 16'(irq_code), 16'd4);
      tick(); tick();
      check("single_hold_valid", 16'(irq_valid), 16'd1);
      check("single_hold_code", 16'(irq_code), 16'd4);
      irq_ack = 1'b1; tick();
      check("single_ack_valid", 16'(irq_valid), 16'd0);
      check("single_ack_pend", pend_vec, 16'h0000);
      irq_ack = 1'b0; tick();
      check("single_gap_valid", 16'(irq_valid), 16'd0);
      tick();
      check("single_idle_valid", 16'(irq_valid), 16'd0);

      // Two simultaneous edges: bits 3 then 1
      irq_in = 16'h0000; tick();
      irq_in = 16'h000A; tick();
      check("multi_pend", pend_vec, 16'h000A);
      tick();
      check("multi_valid_a", 16'(irq_valid), 16'd1);
      check("multi_code_a", 16'(irq_code), 16'd3);
      irq_ack = 1'b1; tick();
      check("multi_ack_a_valid", 16'(irq_valid), 16'd0);
      check("multi_ack_a_pend", pend_vec, 16'h0002);
      irq_ack = 1'b0; tick();
      check("multi_gap_valid", 16'(irq_valid), 16'd0);
      tick();
      check("multi_valid_b", 16'(irq_valid), 16'd1);
      check("multi_code_b", 16'(irq_code), 16'd1);
      irq_ack = 1'b1; tick();
      check("multi_ack_b_pend", pend_vec, 16'h0000);
      irq_ack = 1'b0; tick();

      // Masked line 7 stays hidden until re-enabled
      irq_in = 16'h0000; mask_wr = 1'b1; mask_data = 16'hFF7F; tick();
      mask_wr = 1'b0; irq_in = 16'h0080; tick();
      tick();
      check("mask_pend_hidden", pend_vec, 16'h0000);
      check("mask_valid_low", 16'(irq_valid), 16'd0);
      mask_wr = 1'b1; mask_data = 16'hFFFF; tick();
      mask_wr = 1'b0;
      check("mask_pend_visible", pend_vec, 16'h0080);
      tick();
      check("mask_valid", 16'(irq_valid), 16'd1);
      check("mask_code", 16'(irq_code), 16'd7);
      // Mask change during WAIT_ACK does not disturb the grant
      mask_wr = 1'b1; mask_data = 16'h0000; tick();
      mask_wr = 1'b0;
      check("mask_wait_code", 16'(irq_code), 16'd7);
      check("mask_wait_valid", 16'(irq_valid), 16'd1);
      irq_ack = 1'b1; tick();
      irq_ack = 1'b0; mask_wr = 1'b1; mask_data = 16'hFFFF; tick();
      mask_wr = 1'b0;
      check("mask_cleared_pend", pend_vec, 16'h0000);
      tick();

      // Set wins: new edge on bit 9 at its own ack edge
      irq_in = 16'h0000; tick();
      irq_in = 16'h0200; tick();
      tick();
      check("setwin_code", 16'(irq_code), 16'd9);
      irq_in = 16'h0000; tick();
      irq_in = 16'h0200; irq_ack = 1'b1; tick();
      check("setwin_ack_valid", 16'(irq_valid), 16'd0);
      check("setwin_ack_pend", pend_vec, 16'h0200);
      irq_ack = 1'b0; tick();
      check("setwin_gap_valid", 16'(irq_valid), 16'd0);
      tick();
      check("setwin_regrant_valid", 16'(irq_valid), 16'd1);
      check("setwin_regrant_code", 16'(irq_code), 16'd9);
`ifdef IRQ_OVERFLOW_CNT_EN
      check("ovf_cnt", 16'(overflow_cnt), 16'd1);
`endif
      irq_ack = 1'b1; tick();
      irq_ack = 1'b0; tick();
      check("setwin_final_pend", pend_vec, 16'h0000);
`ifdef IRQ_OVERFLOW_CNT_EN
      overflow_clr = 1'b1; tick();
      overflow_clr = 1'b0;
      check("ovf_clr", 16'(overflow_cnt), 16'd0);
`endif

      // Reset in the middle of a handshake for code 2
      irq_in = 16'h0000; tick();
      irq_in = 16'h0004; tick();
      tick();
      check("midrst_pre_code", 16'(irq_code), 16'd2);
      check("midrst_pre_valid", 16'(irq_valid), 16'd1);
      rst = 1'b1; tick();
      check("midrst_valid", 16'(irq_valid), 16'd0);
      check("midrst_pend", pend_vec, 16'h0000);
      check("midrst_code", 16'(irq_code), 16'd0);
      rst = 1'b0; irq_ack = 1'b1; tick();
      check("midrst_ack_ignored", 16'(irq_valid), 16'd0);
      irq_ack = 1'b0; mask_wr = 1'b1; mask_data = 16'hFFFF; tick();
      mask_wr = 1'b0; tick();
      check("midrst_no_edge_pend", pend_vec, 16'h0000);
      check("midrst_no_edge_valid", 16'(irq_valid), 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
